sfx_scheduler: RTL

SFX_SCHEDULER -- requirements
Module: sfx_scheduler

---
 rtl/sfx_pkg.sv | 59 +++++
 rtl/sfx_rom.sv | 34 +++
 rtl/sfx_scheduler.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sfx_pkg.sv
// Shared types, constants and note tables for the sound-effect scheduler.
package sfx_pkg;

    localparam int unsigned DIV_W   = 22;
    localparam int unsigned VOL_W   = 5;
    localparam int unsigned STEP_W  = 2;
    localparam int unsigned POS_W   = 5;
    localparam int unsigned KEY_LEN = 2;
    localparam int unsigned ERR_LEN = 4;
    localparam int unsigned BGM_LEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BGM  = 2'd1,
        ST_KEY  = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [1:0] SFX_IDLE = 2'd0;
    localparam logic [1:0] SFX_BGM  = 2'd1;
    localparam logic [1:0] SFX_KEY  = 2'd2;
    localparam logic [1:0] SFX_ERR  = 2'd3;

    localparam logic [DIV_W-1:0] SILENT_DIV = 22'd1;
    localparam logic [DIV_W-1:0] KEY_DIV    = 22'd47778;
    localparam logic [DIV_W-1:0] ERR_DIV    = 22'd227272;

    typedef struct packed {
        logic [DIV_W-1:0] left;
        logic [DIV_W-1:0] right;
    } div_pair_t;

    // Melody line (left channel), one divisor per beat
    localparam logic [DIV_W-1:0] BGM_LEFT [BGM_LEN] = '{
        22'd382219, 22'd340530, 22'd303370, 22'd286344, 22'd255102, 22'd227272, 22'd202478, 22'd191113,
        22'd202478, 22'd227272, 22'd255102, 22'd286344, 22'd303370, 22'd340530, 22'd382219, 22'd303370,
        22'd255102, 22'd191113, 22'd255102, 22'd303370, 22'd382219, 22'd303370, 22'd255102, 22'd227272,
        22'd286344, 22'd227272, 22'd191113, 22'd227272, 22'd255102, 22'd303370, 22'd340530, 22'd202478
    };

    // Bass line (right channel), one divisor per beat
    localparam logic [DIV_W-1:0] BGM_RIGHT [BGM_LEN] = '{
        22'd764467, 22'd1020408, 22'd764467, 22'd1020408, 22'd1145241, 22'd764467, 22'd1145241, 22'd764467,
        22'd909091, 22'd1020408, 22'd909091, 22'd1020408, 22'd1145241, 22'd1020408, 22'd764467, 22'd1020408,
        22'd764467, 22'd1020408, 22'd764467, 22'd1020408, 22'd1145241, 22'd764467, 22'd1145241, 22'd764467,
        22'd1145241, 22'd764467, 22'd1145241, 22'd764467, 22'd1020408, 22'd909091, 22'd1020408, 22'd764467
    };

    // Map FSM state to the externally visible effect code
    function automatic logic [1:0] sfx_code(input state_t s);
        case (s)
            ST_BGM:  return SFX_BGM;
            ST_KEY:  return SFX_KEY;
            ST_ERR:  return SFX_ERR;
            default: return SFX_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/sfx_rom.sv
// Divisor lookup for every effect: state plus step/bgm position -> left/right divisors.
module sfx_rom
    import sfx_pkg::*;
(
    input  state_t            state,
    input  logic [STEP_W-1:0] step,
    input  logic [POS_W-1:0]  bgm_pos,
    output div_pair_t         divs_c
);

    // Select the divisor pair for the current effect and beat
    always_comb begin
        divs_c.left  = SILENT_DIV;
        divs_c.right = SILENT_DIV;
        case (state)
            ST_BGM: begin
                divs_c.left  = BGM_LEFT[bgm_pos];
                divs_c.right = BGM_RIGHT[bgm_pos];
            end
            ST_KEY: begin
                if (step == '0) begin
                    divs_c.left  = KEY_DIV;
                    divs_c.right = KEY_DIV;
                end
            end
            ST_ERR: begin
                divs_c.left  = ERR_DIV;
                divs_c.right = ERR_DIV;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sfx_scheduler.sv
// Prioritised sound-effect scheduler: ERR > KEY > BGM > IDLE, beat-timed, registered outputs.
module sfx_scheduler
    import sfx_pkg::*;
#(
    parameter int unsigned TICK_DIV = 12_500_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_req,
    input  logic             err_req,
    input  logic             bgm_en,
    input  logic [VOL_W-1:0] vol_in,
    output logic [DIV_W-1:0] note_div_left,
    output logic [DIV_W-1:0] note_div_right,
    output logic [VOL_W-1:0] volume,
    output logic             busy,
    output logic [1:0]       sfx_id
);

    localparam int unsigned    TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    state_t              state, nxt_state;
    logic [STEP_W-1:0]   step, nxt_step;
    logic [POS_W-1:0]    bgm_pos, nxt_pos;
    logic [TICK_W-1:0]   tick_cnt, nxt_tick;
    logic                key_pend, nxt_pend;
    logic                tick_c, last_c, pend_c, restart_c;
    div_pair_t           divs_c;

    assign tick_c = (tick_cnt == TICK_LAST);
    assign last_c = (state == ST_KEY) ? (step == STEP_W'(KEY_LEN - 1))
                                      : (step == STEP_W'(ERR_LEN - 1));
    // A key request during ERR is remembered; a second one is absorbed
    assign pend_c = key_pend | (key_req && (state == ST_ERR));

    // Next state, step/position counters, beat timer and pending key
    always_comb begin
        nxt_state = state;
        nxt_step  = step;
        nxt_pos   = bgm_pos;
        nxt_pend  = pend_c;
        restart_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bgm_en) nxt_state = ST_BGM;
            end
            ST_BGM: begin
                if (!bgm_en)     nxt_state = ST_IDLE;
                else if (tick_c) nxt_pos   = bgm_pos + 1'b1;
            end
            default: begin
                if (tick_c) begin
                    if (!last_c) begin
                        nxt_step = step + 1'b1;
                    end else begin
                        nxt_step = '0;
                        if (pend_c) begin
                            nxt_state = ST_KEY;
                            nxt_pend  = 1'b0;
                        end else if (bgm_en) begin
                            nxt_state = ST_BGM;
                        end else begin
                            nxt_state = ST_IDLE;
                        end
                    end
                end
            end
        endcase
        if (err_req) begin
            nxt_state = ST_ERR;
            nxt_step  = '0;
            nxt_pend  = pend_c | key_req;
            restart_c = 1'b1;
        end else if (key_req && (state != ST_ERR)) begin
            nxt_state = ST_KEY;
            nxt_step  = '0;
            restart_c = 1'b1;
        end
        if (!bgm_en) nxt_pos = '0;
        // Beat timer restarts on every entry or restart so each effect starts a full beat
        if (restart_c || (nxt_state != state) || (state == ST_IDLE) || tick_c) begin
            nxt_tick = '0;
        end else begin
            nxt_tick = tick_cnt + 1'b1;
        end
    end

    sfx_rom u_rom (
        .state   (nxt_state),
        .step    (nxt_step),
        .bgm_pos (nxt_pos),
        .divs_c  (divs_c)
    );

    // State and output registers; outputs reflect the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            step           <= '0;
            bgm_pos        <= '0;
            tick_cnt       <= '0;
            key_pend       <= 1'b0;
            note_div_left  <= SILENT_DIV;
            note_div_right <= SILENT_DIV;
            volume         <= '0;
            busy           <= 1'b0;
            sfx_id         <= SFX_IDLE;
        end else begin
            state          <= nxt_state;
            step           <= nxt_step;
            bgm_pos        <= nxt_pos;
            tick_cnt       <= nxt_tick;
            key_pend       <= nxt_pend;
            note_div_left  <= divs_c.left;
            note_div_right <= divs_c.right;
            volume         <= (nxt_state == ST_IDLE) ? '0 : vol_in;
            busy           <= (nxt_state == ST_KEY) || (nxt_state == ST_ERR);
            sfx_id         <= sfx_code(nxt_state);
        end
    end

endmodule
